truth_table_scanner: RTL

- Sequential test companion for the gate-level combinational exercise modules. It drives an N-input vector onto a combinational function under test and reads its single output back.
- It sweeps all 2^N input combinations in ascending order, waits a settle period for each, and samples the function output into a truth-table register.
- When the sweep ends it compares the captured table against an expected minterm mask and reports the result.
- It sits on the board or bench side of the function: it generates the inputs (x, y, z, ...) and reads the output (F).

---
 rtl/truth_table_scanner_pkg.sv | 23 ++
 rtl/truth_table_scanner_if.sv | 39 +++
 rtl/truth_table_scanner_settle_timer.sv | 39 +++
 rtl/truth_table_scanner.sv | 131 +++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_scanner_pkg
// Purpose : Shared types and helpers for the truth-table scanner.
//           - state_t  : 2-bit FSM state encoding (IDLE/HOLD/SAMPLE/FINISH)
//           - table_w  : truth-table width (2**n) for an n-input function
// Revision: 1.0 - initial release
// ============================================================================
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic int table_w(input int n);
    return 2 ** n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_scanner_if.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_scanner_if
// Purpose : Bundles the scanner's control and function-under-test signals.
//   start     : request a sweep            expected  : expected minterm mask
//   f_in      : function output            vec_out   : vector to the function
//   busy/done : sweep status / completion  table_out : captured truth table
//   match     : table_out == latched expected
//   Modports  : slave  = scanner side, master = board/bench side.
// Revision: 1.0 - initial release
// ============================================================================
interface truth_table_scanner_if #(
  parameter int N_IN = 3
);
  import truth_table_scanner_pkg::*;

  localparam int TW = table_w(N_IN);

  logic            start;
  logic [TW-1:0]   expected;
  logic            f_in;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
  logic            match;

  modport slave (
    input  start, expected, f_in,
    output vec_out, busy, done, table_out, match
  );

  modport master (
    output start, expected, f_in,
    input  vec_out, busy, done, table_out, match
  );

endinterface
`default_nettype wire

// File: rtl/truth_table_scanner_settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_scanner_settle_timer
// Purpose : Loadable down-counter with a zero flag; times the HOLD phase.
//   clk, rst : clock / synchronous active-high reset
//   load     : reload the counter with LOAD_VALUE
//   dec      : decrement (saturates at zero)
//   zero     : counter is zero
// Revision: 1.0 - initial release
// ============================================================================
module truth_table_scanner_settle_timer #(
  parameter int LOAD_VALUE = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic load,
  input  wire logic dec,
  output logic      zero
);

  localparam int            CW   = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LOAD_VALUE);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_scanner
// Purpose : Sweeps all 2**N_IN input vectors onto a combinational function,
//           holds each for SETTLE_CYCLES+1 cycles, samples the function output
//           into a truth table and compares it with a latched expected mask.
//   clk, rst : clock / synchronous active-high reset
//   bus      : truth_table_scanner_if.slave (start, expected, f_in, vec_out,
//              busy, done, table_out, match)
// Revision: 1.0 - initial release
// ============================================================================
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input wire logic              clk,
  input wire logic              rst,
  truth_table_scanner_if.slave  bus
);

  localparam int            TW   = table_w(N_IN);
  // One extra bit on idx keeps the last-index test unambiguous.
  localparam logic [N_IN:0] LAST = (N_IN + 1)'(TW - 1);

  state_t          state, state_nxt;
  logic [N_IN:0]   idx;
  logic [TW-1:0]   table_q;
  logic [TW-1:0]   exp_q;
  logic            busy_q;
  logic            done_q;
  logic            match_q;

  logic            accept;
  logic            sample;
  logic            finish;
  logic            timer_load;
  logic            timer_dec;
  logic            timer_zero;

  truth_table_scanner_settle_timer #(
    .LOAD_VALUE (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    sample     = 1'b0;
    finish     = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Timer starts at SETTLE_CYCLES, so HOLD lasts SETTLE_CYCLES+1 cycles.
        if (timer_zero) state_nxt = ST_SAMPLE;
        else            timer_dec = 1'b1;
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (idx == LAST) begin
          state_nxt = ST_FINISH;
        end else begin
          timer_load = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_FINISH: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      table_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        exp_q   <= bus.expected;
        table_q <= '0;
        match_q <= 1'b0;
        idx     <= '0;
        busy_q  <= 1'b1;
      end
      if (sample) begin
        table_q[idx[N_IN-1:0]] <= bus.f_in;
        // Last vector stays on vec_out through FINISH.
        if (idx != LAST) idx <= idx + 1'b1;
      end
      if (finish) begin
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        match_q <= (table_q == exp_q);
      end
    end
  end

  assign bus.vec_out   = idx[N_IN-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.match     = match_q;

endmodule
`default_nettype wire
